// File: rtl/fifo.sv
// ============================================================================
// fifo : single-clock show-ahead FIFO with occupancy counter
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic write_en,
    input  T     write_data,
    input  logic read_en,
    output T     read_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign full   = (r_count == C_FULL_CNT);
    assign empty  = (r_count == '0);
    assign w_push = write_en && !full;
    assign w_pop  = read_en && !empty;

    // Head is exposed combinationally; forced to zero so nothing stale leaks out.
    assign read_data = empty ? T'('0) : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: scoreboard queue of accepted pushes, popped on accepted reads.
`default_nettype none

module tb_fifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        write_en;
    logic [31:0] write_data;
    logic        read_en;
    logic [31:0] read_data;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_q [$];

    fifo #(
        .T     (logic [31:0]),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle from a negedge; the scoreboard decides acceptance from
    // its own occupancy and checks the head on every accepted pop.
    task automatic step(input logic we, input logic [31:0] wd, input logic re);
        logic push_ok;
        logic pop_ok;
        logic [31:0] exp;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        push_ok    = we && (model_q.size() < DEPTH);
        pop_ok     = re && (model_q.size() != 0);
        if (pop_ok) begin
            exp = model_q.pop_front();
            checks++;
            if (read_data !== exp) begin
                errors++;
                $display("FAIL pop_data: read_data=%h expected=%h", read_data, exp);
            end
        end
        if (push_ok) model_q.push_back(wd);
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        write_en = 1'b0;
        read_en = 1'b0;
        write_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_in: empty=%b full=%b data=%h expected 1 0 0", empty, full, read_data);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: empty=%b full=%b data=%h expected 1 0 0", empty, full, read_data);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h10 + i, 1'b0);
            checks++;
            if (empty !== 1'b0 || full !== (i == 3)) begin
                errors++;
                $display("FAIL fill_%0d: empty=%b full=%b expected 0 %b", i, empty, full, (i == 3));
            end
        end
        step(1'b1, 32'h14, 1'b0);
        checks++;
        if (full !== 1'b1 || read_data !== 32'h10) begin
            errors++;
            $display("FAIL overflow: full=%b head=%h expected 1 00000010", full, read_data);
        end
    endtask

    task automatic test_partial_drain();
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        checks++;
        if (read_data !== 32'h12 || full !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL partial_drain: head=%h full=%b empty=%b expected 00000012 0 0", read_data, full, empty);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 32'h20, 1'b0);
        step(1'b1, 32'h21, 1'b0);
        step(1'b1, 32'h22, 1'b0);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL wrap_full: full=%b expected 1", full);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL wrap_drained: empty=%b full=%b data=%h expected 1 0 0", empty, full, read_data);
        end
        checks++;
        if (model_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_model: entries=%0d expected 0", model_q.size());
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 32'h30, 1'b0);
        step(1'b1, 32'h31, 1'b0);
        step(1'b1, 32'h32, 1'b1);
        checks++;
        if (read_data !== 32'h31 || empty !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL simul_mid: head=%h empty=%b full=%b expected 00000031 0 0", read_data, empty, full);
        end
        step(1'b1, 32'h33, 1'b0);
        step(1'b1, 32'h34, 1'b0);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL simul_fill: full=%b expected 1", full);
        end
        step(1'b1, 32'h35, 1'b1);
        checks++;
        if (full !== 1'b0 || read_data !== 32'h32) begin
            errors++;
            $display("FAIL simul_full: full=%b head=%h expected 0 00000032", full, read_data);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_drain: empty=%b expected 1 (35 must have been dropped)", empty);
        end
        step(1'b1, 32'h36, 1'b1);
        checks++;
        if (empty !== 1'b0 || read_data !== 32'h36) begin
            errors++;
            $display("FAIL simul_empty: empty=%b head=%h expected 0 00000036", empty, read_data);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_last: empty=%b expected 1", empty);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 32'h40, 1'b0);
        step(1'b1, 32'h41, 1'b0);
        step(1'b1, 32'h42, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: empty=%b full=%b data=%h expected 1 0 0", empty, full, read_data);
        end
        #1;
        reset = 1'b1;
        model_q.delete();
        @(negedge clk);
        step(1'b1, 32'hAA, 1'b0);
        checks++;
        if (empty !== 1'b0 || read_data !== 32'hAA) begin
            errors++;
            $display("FAIL post_reset_push: empty=%b head=%h expected 0 000000aa", empty, read_data);
        end
        step(1'b0, '0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_partial_drain();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
